// File: rtl/wb_host_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant,
// per-cyc bus locking and a stb-without-ack watchdog that terminates with an error ack.
module wb_host_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,

  output logic [1:0]  grant_o,
  output logic        timeout_irq_o,
  input  logic        irq_clr_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  // ERR is entered on the edge where the count would reach TIMEOUT_CYC-1,
  // so the error ack lands in the TIMEOUT_CYC-th granted strobe cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ERR
  } state_e;

  state_e           state_q;
  logic [1:0]       grant_q;
  logic             rr_last_q;
  logic [CNT_W-1:0] cnt_q;
  logic             irq_q;

  logic gnt_cyc;
  logic gnt_stb;
  logic busy;
  logic in_err;
  logic pick_m1;
  logic slv_ack;

  assign gnt_cyc = (grant_q[0] & m0_cyc_i) | (grant_q[1] & m1_cyc_i);
  assign gnt_stb = (grant_q[0] & m0_stb_i) | (grant_q[1] & m1_stb_i);
  assign busy    = (state_q == ST_BUSY);
  assign in_err  = (state_q == ST_ERR);

  // rr_last_q = 1 means M1 won last, so a tie goes to M0.
  assign pick_m1 = m1_cyc_i & (~m0_cyc_i | ~rr_last_q);

  assign s_cyc_o = busy & gnt_cyc;
  assign s_stb_o = busy & gnt_cyc & gnt_stb;
  assign slv_ack = s_stb_o & s_ack_i;

  always_comb begin
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (s_cyc_o) begin
      if (grant_q[1]) begin
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end else begin
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
    end
  end

  always_comb begin
    m0_ack_o = grant_q[0] & (slv_ack | in_err);
    m1_ack_o = grant_q[1] & (slv_ack | in_err);
    m0_dat_o = '0;
    m1_dat_o = '0;
    if (in_err) begin
      if (grant_q[0]) m0_dat_o = ERR_DATA;
      if (grant_q[1]) m1_dat_o = ERR_DATA;
    end else if (busy) begin
      if (grant_q[0]) m0_dat_o = s_dat_i;
      if (grant_q[1]) m1_dat_o = s_dat_i;
    end
  end

  assign grant_o       = grant_q;
  assign timeout_irq_o = irq_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      // A timeout in the same cycle as a clear keeps the interrupt set.
      irq_q <= in_err | (irq_q & ~irq_clr_i);

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (m0_cyc_i | m1_cyc_i) begin
            state_q   <= ST_BUSY;
            grant_q   <= pick_m1 ? 2'b10 : 2'b01;
            rr_last_q <= pick_m1;
          end
        end
        ST_BUSY: begin
          if (!gnt_cyc) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            cnt_q   <= '0;
          end else if (s_stb_o & ~s_ack_i) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_ERR;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_q <= '0;
          end
        end
        ST_ERR: begin
          cnt_q <= '0;
          if (gnt_cyc) begin
            state_q <= ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
